// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// FSM states, keyboard command bytes and small helpers.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_DATA,
        ST_ACK,
        ST_WAITIDLE
    } state_t;

    // Command bytes the host sends, plus the byte the keyboard answers with.
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // PS/2 frames use odd parity: data ones plus parity bit is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, with a
// falling-edge strobe on the synchronized clock. Lines idle high, so
// the flops reset to 1 to avoid a spurious edge after reset.
module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_meta, data_meta, clk_prev;

    // Resynchronize both pins and keep the previous clock sample for edge detect.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, requests to send,
// then shifts one byte out on device-generated clock falls, checks the
// device ACK and waits for the bus to go idle again.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int CW = $clog2(max3(INHIBIT_CYCLES, RTS_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] tmo;
    logic [3:0]    bitc;
    logic [8:0]    shift;   // {parity, data}
    logic          clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall)
    );

    // Transfer FSM; every output is registered so the pins never glitch,
    // and data_oe only moves on a clock fall while the device is not sampling.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            tmo         <= '0;
            bitc        <= '0;
            shift       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift       <= {odd_parity(tx_data), tx_data};
                        cnt         <= '0;
                        state       <= ST_INHIBIT;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        state       <= ST_RTS;
                        ps2_data_oe <= 1'b1;   // start bit
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RTS: begin
                    if (cnt == RTS_LAST) begin
                        cnt        <= '0;
                        state      <= ST_DATA;
                        ps2_clk_oe <= 1'b0;    // hand the clock to the device
                        bitc       <= '0;
                        tmo        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA, ST_ACK, ST_WAITIDLE: begin
                    tmo <= tmo + 1'b1;
                    if (tmo == TMO_LAST) begin
                        state       <= ST_IDLE;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                        tx_err      <= 1'b1;
                    end else if (state == ST_DATA) begin
                        if (clk_fall) begin
                            bitc <= bitc + 1'b1;
                            if (bitc == 4'd9) begin
                                ps2_data_oe <= 1'b0;   // stop bit, released high
                                state       <= ST_ACK;
                            end else begin
                                ps2_data_oe <= ~shift[bitc];   // data LSB first, then parity
                            end
                        end
                    end else if (state == ST_ACK) begin
                        if (clk_fall) begin
                            bitc <= bitc + 1'b1;
                            if (data_sync) begin
                                state    <= ST_IDLE;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                                tx_err   <= 1'b1;
                            end else begin
                                state <= ST_WAITIDLE;
                            end
                        end
                    end else begin
                        if (clk_sync && data_sync) begin
                            state    <= ST_IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            tx_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-level PS/2 device model on open-drain
// lines, frames checked against the bit order and parity rules.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH = 20;
    localparam int RTS = 8;
    localparam int TMO = 600;
    localparam int H   = 8;    // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       bfm_clk_low, bfm_data_low;
    logic       clk_line, data_line;

    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int exp_done = 0, exp_err = 0;

    assign clk_line  = ~(ps2_clk_oe  | bfm_clk_low);
    assign data_line = ~(ps2_data_oe | bfm_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    // Tally result pulses so pulses landing inside device-model tasks are not lost.
    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Odd parity from a plain ones count.
    function automatic logic exp_par(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: clocks 11 falls, reads data at each rise, optionally ACKs.
    task automatic bfm(input bit ack, input int abort_at, output logic [9:0] bits);
        bits = '0;
        repeat (4) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            bfm_clk_low = 1'b1;
            if (k == abort_at) begin
                repeat (H/2) @(negedge clk);
                clrn = 1'b0;
                #1;
                return;
            end
            repeat (H) @(negedge clk);
            bfm_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = data_line;
            if (k == 10 && ack) begin
                repeat (H/2) @(negedge clk);
                bfm_data_low = 1'b1;
                repeat (H/2) @(negedge clk);
            end else if (k < 11) begin
                repeat (H) @(negedge clk);
            end else begin
                repeat (H/2) @(negedge clk);
                bfm_data_low = 1'b0;
            end
        end
    endtask

    // Follows one accepted transfer from INHIBIT to its result pulse.
    task automatic run_frame(input logic [7:0] d, input bit ack, input int abort_at, input string tag);
        int c, bd, be;
        logic [9:0] bits;
        bit got_done, got_err;
        bd = done_cnt;
        be = err_cnt;
        c = 0;
        while (ps2_clk_oe && !ps2_data_oe && c < INH + 50) begin c++; @(negedge clk); end
        chk($sformatf("%s_inhibit_len", tag), c, INH);
        c = 0;
        while (ps2_clk_oe && ps2_data_oe && c < RTS + 50) begin c++; @(negedge clk); end
        chk($sformatf("%s_rts_len", tag), c, RTS);
        chk($sformatf("%s_start_bit", tag), {ps2_clk_oe, data_line}, 2'b00);
        bfm(ack, abort_at, bits);
        if (abort_at != 0) return;
        chk($sformatf("%s_frame", tag), bits, {1'b1, exp_par(d), d});
        c = 0;
        while (!(tx_done || tx_err) && done_cnt == bd && err_cnt == be && c < 200) begin
            c++;
            @(negedge clk);
        end
        got_done = tx_done || (done_cnt != bd);
        got_err  = tx_err  || (err_cnt  != be);
        chk($sformatf("%s_result", tag), {got_done, got_err}, ack ? 2'b10 : 2'b01);
        chk($sformatf("%s_idle_pins", tag), {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        if (ack) exp_done++; else exp_err++;
    endtask

    initial begin
        int c;
        logic [7:0] rd;
        bit ra;
        clrn = 1'b0; tx_valid = 1'b0; tx_data = '0;
        bfm_clk_low = 1'b0; bfm_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_err}, 6'b100000);
        clrn = 1'b1;

        // LED command with ACK
        start_tx(CMD_SET_LED);
        run_frame(CMD_SET_LED, 1'b1, 0, "led");

        // parity boundaries
        start_tx(8'h01);
        run_frame(8'h01, 1'b1, 0, "par01");
        start_tx(8'h00);
        run_frame(8'h00, 1'b1, 0, "par00");

        // device does not ACK
        start_tx(8'h55);
        run_frame(8'h55, 1'b0, 0, "nak");
        chk("nak_no_done", done_cnt, exp_done);

        // device never clocks: timeout measured from clock release
        start_tx(CMD_ENABLE);
        c = 0;
        while (!(!ps2_clk_oe && ps2_data_oe) && c < INH + RTS + 50) begin c++; @(negedge clk); end
        c = 0;
        while (!tx_err && c < 2 * TMO) begin c++; @(negedge clk); end
        chk("timeout_len", c, TMO);
        chk("timeout_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done}, 5'b10000);
        exp_err++;

        // reset during inhibit releases the clock at once
        start_tx(8'h12);
        repeat (3) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("rst_inhibit", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 4'b0001);
        @(negedge clk);
        clrn = 1'b1;

        // reset at fall 5 of a reset command, then a clean enable command
        start_tx(CMD_RESET);
        run_frame(CMD_RESET, 1'b1, 5, "abort");
        chk("rst_data", {ps2_clk_oe, ps2_data_oe, busy, tx_ready}, 4'b0001);
        bfm_clk_low = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        repeat (4) @(negedge clk);
        start_tx(CMD_ENABLE);
        run_frame(CMD_ENABLE, 1'b1, 0, "after_rst");

        // valid held during a transfer: no queueing, second byte taken afterwards
        @(negedge clk);
        tx_data  = CMD_SET_LED;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'hAA;
        run_frame(CMD_SET_LED, 1'b1, 0, "hold_first");
        @(negedge clk);
        tx_valid = 1'b0;
        run_frame(8'hAA, 1'b1, 0, "hold_second");

        // random bytes with random ACK behaviour
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            start_tx(rd);
            run_frame(rd, ra, 0, $sformatf("rand%0d", i));
        end

        repeat (4) @(negedge clk);
        chk("done_total", done_cnt, exp_done);
        chk("err_total", err_cnt, exp_err);
        chk("done_err_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
